// File: rtl/pixel_status_pio.sv
// Avalon-MM parallel input port for classifier status lines: synchronized
// DATA, per-bit edge capture with write-1-to-clear, and a masked level irq.
module pixel_status_pio #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_CAP  = 2'd3
  } reg_addr_e;

  reg_addr_e        sel;
  logic             wr_en;
  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign sel          = reg_addr_e'(address);
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    edge_det = '0;
    if (EDGE_TYPE == 0)
      edge_det = s2 & ~s3;
    else if (EDGE_TYPE == 1)
      edge_det = ~s2 & s3;
    else
      edge_det = s2 ^ s3;
  end

  always_comb begin
    clr_mask = '0;
    if (wr_en && sel == ADDR_CAP)
      clr_mask = writedata[WIDTH-1:0];
  end

  // Zero-extend by filling first, so WIDTH=32 needs no zero-width replication.
  always_comb begin
    rd_mux = '0;
    case (sel)
      ADDR_DATA: rd_mux[WIDTH-1:0] = s2;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_CAP:  rd_mux[WIDTH-1:0] = edge_cap;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= s2;
      if (wr_en && sel == ADDR_MASK)
        irq_mask <= writedata[WIDTH-1:0];
      // Set is OR'd after the clear so a coincident edge keeps the bit.
      edge_cap <= (edge_cap & ~clr_mask) | edge_det;
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pixel_status_pio.sv
// Bench for pixel_status_pio: three instances (rising, falling, any edge)
// sharing one bus; register reads are checked through a scoreboard queue.
module tb_pixel_status_pio;

  localparam int W = 10;
  localparam int OP_SET = 0, OP_IDLE = 1, OP_READ = 2, OP_WRITE = 3;
  localparam int NSTEP = 17;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port0, in_port1, in_port2;
  logic [31:0]  readdata0, readdata1, readdata2;
  logic         irq0, irq1, irq2;

  typedef struct {
    int          op;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } step_t;

  typedef struct {
    string       name;
    int          dut;
    logic [31:0] exp;
  } sb_t;

  step_t tbl [NSTEP];
  sb_t   sb_q [$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  pixel_status_pio #(.WIDTH(W), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata0),
    .in_port(in_port0), .irq(irq0));

  pixel_status_pio #(.WIDTH(W), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata1),
    .in_port(in_port1), .irq(irq1));

  pixel_status_pio #(.WIDTH(W), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port2), .irq(irq2));

  function automatic logic [31:0] rdata(input int d);
    case (d)
      0:       return readdata0;
      1:       return readdata1;
      default: return readdata2;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e, input string nm);
    sb_t item;
    @(negedge clk);
    bus_idle();
    address = a;
    sb_q.push_back('{nm, d, e});
    @(posedge clk);
    #1;
    item = sb_q.pop_front();
    check(item.name, rdata(item.dut), item.exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b1;
    address   = 2'd0;
    writedata = '0;
    bus_idle();
    in_port0  = '0;
    in_port1  = 10'h3FF;
    in_port2  = 10'h001;

    tbl[0]  = '{OP_SET,   2'd0, 32'h005,      32'h0,   1'b0};
    tbl[1]  = '{OP_IDLE,  2'd0, 32'h0,        32'h0,   1'b0};
    tbl[2]  = '{OP_IDLE,  2'd0, 32'h0,        32'h0,   1'b0};
    tbl[3]  = '{OP_READ,  2'd3, 32'h0,        32'h005, 1'b0};
    tbl[4]  = '{OP_READ,  2'd0, 32'h0,        32'h005, 1'b0};
    tbl[5]  = '{OP_WRITE, 2'd2, 32'h004,      32'h0,   1'b1};
    tbl[6]  = '{OP_READ,  2'd2, 32'h0,        32'h004, 1'b1};
    tbl[7]  = '{OP_WRITE, 2'd3, 32'h004,      32'h0,   1'b0};
    tbl[8]  = '{OP_READ,  2'd3, 32'h0,        32'h001, 1'b0};
    tbl[9]  = '{OP_WRITE, 2'd0, 32'hFFFFFFFF, 32'h0,   1'b0};
    tbl[10] = '{OP_WRITE, 2'd1, 32'hFFFFFFFF, 32'h0,   1'b0};
    tbl[11] = '{OP_READ,  2'd0, 32'h0,        32'h005, 1'b0};
    tbl[12] = '{OP_READ,  2'd1, 32'h0,        32'h0,   1'b0};
    tbl[13] = '{OP_WRITE, 2'd2, 32'hFFFFFFFF, 32'h0,   1'b1};
    tbl[14] = '{OP_READ,  2'd2, 32'h0,        32'h3FF, 1'b1};
    tbl[15] = '{OP_WRITE, 2'd3, 32'h001,      32'h0,   1'b0};
    tbl[16] = '{OP_READ,  2'd3, 32'h0,        32'h0,   1'b0};

    // Reset state, before any clock edge
    #2 reset_n = 1'b0;
    #1;
    check("rst_rd0", readdata0, 32'h0);
    check("rst_rd1", readdata1, 32'h0);
    check("rst_rd2", readdata2, 32'h0);
    check("rst_irq", {29'd0, irq2, irq1, irq0}, 32'h0);
    cycles(3);
    reset_n = 1'b1;

    // Bit already high at release is seen as a rising edge (any-edge instance)
    cycles(4);
    rd(2, 2'd3, 32'h001, "release_cap");
    rd(1, 2'd3, 32'h000, "release_cap_fall");
    wr(2'd3, 32'h3FF);

    // Register map / basic capture table on the rising-edge instance
    for (int i = 0; i < NSTEP; i++) begin
      sb_t item;
      @(negedge clk);
      bus_idle();
      address = tbl[i].addr;
      case (tbl[i].op)
        OP_SET:   in_port0 = tbl[i].data[W-1:0];
        OP_WRITE: begin
          chipselect = 1'b1;
          write_n    = 1'b0;
          writedata  = tbl[i].data;
        end
        OP_READ:  sb_q.push_back('{$sformatf("tbl%0d_rd", i), 0, tbl[i].exp_rd});
        default:  ;
      endcase
      @(posedge clk);
      #1;
      if (tbl[i].op == OP_READ) begin
        item = sb_q.pop_front();
        check(item.name, rdata(item.dut), item.exp);
      end
      check($sformatf("tbl%0d_irq", i), {31'd0, irq0}, {31'd0, tbl[i].exp_irq});
    end
    @(negedge clk);
    bus_idle();

    // Latency: irq (mask all ones) rises only after the second edge past s1
    @(negedge clk);
    in_port0 = 10'h007;
    @(posedge clk); #1; check("lat_k",   {31'd0, irq0}, 32'h0);
    @(posedge clk); #1; check("lat_k1",  {31'd0, irq0}, 32'h0);
    @(posedge clk); #1; check("lat_k2",  {31'd0, irq0}, 32'h1);
    wr(2'd3, 32'h3FF);

    // Clear coincident with a new rising edge on bit 0: set wins
    @(negedge clk);
    in_port0 = 10'h006;
    cycles(4);
    wr(2'd3, 32'h3FF);
    rd(0, 2'd3, 32'h000, "pre_setwin_cap");
    @(negedge clk);
    in_port0 = 10'h007;
    @(negedge clk);
    wr(2'd3, 32'h001);
    rd(0, 2'd3, 32'h001, "setwin_cap");
    check("setwin_irq", {31'd0, irq0}, 32'h1);

    // Masking drops irq but keeps the captured bit
    wr(2'd2, 32'h000);
    check("mask0_irq", {31'd0, irq0}, 32'h0);
    rd(0, 2'd3, 32'h001, "mask0_cap_kept");
    wr(2'd3, 32'h001);

    // Two-cycle pulse on bit 4 captured exactly once
    @(negedge clk);
    in_port0 = 10'h017;
    cycles(2);
    in_port0 = 10'h007;
    cycles(4);
    rd(0, 2'd3, 32'h010, "pulse_cap");
    wr(2'd3, 32'h3FF);

    // Falling-edge instance
    @(negedge clk);
    in_port1 = 10'h1FF;
    cycles(4);
    rd(1, 2'd3, 32'h200, "fall_cap");

    // Any-edge instance: bit 3 toggled twice with a clear in between
    @(negedge clk);
    in_port2 = 10'h009;
    cycles(4);
    rd(2, 2'd3, 32'h008, "any_rise_cap");
    wr(2'd3, 32'h008);
    rd(2, 2'd3, 32'h000, "any_cleared");
    @(negedge clk);
    in_port2 = 10'h001;
    cycles(4);
    rd(2, 2'd3, 32'h008, "any_fall_cap");

    // Fully armed, then asynchronous reset between clock edges
    wr(2'd3, 32'h3FF);
    @(negedge clk);
    in_port0 = 10'h000;
    cycles(4);
    in_port0 = 10'h3FF;
    cycles(4);
    wr(2'd2, 32'h3FF);
    rd(0, 2'd3, 32'h3FF, "armed_cap");
    check("armed_irq", {31'd0, irq0}, 32'h1);
    #1 reset_n = 1'b0;
    in_port0 = 10'h000;
    #1;
    check("async_rst_irq", {31'd0, irq0}, 32'h0);
    check("async_rst_rd", readdata0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(0, 2'd2, 32'h000, "post_rst_mask");
    rd(0, 2'd3, 32'h000, "post_rst_cap");
    check("post_rst_irq", {31'd0, irq0}, 32'h0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
